// File: rtl/stage1if.sv
// Instruction fetch stage: in-order word fetch, small instruction buffer, stall and redirect.
// Define STAGE1IF_PERF_EN to add perf_bubble_cnt_out, a saturating output-bubble counter.
`timescale 1ns/1ps
module stage1if #(
  parameter logic [23:0] RESET_PC   = 24'h000000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_in,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [23:0] flush_pc_in,
  output logic        imem_req,
  output logic [23:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [23:0] imem_rdata,
  output logic        enable_out,
  output logic [23:0] pc_out,
  output logic [23:0] instr_out
`ifdef STAGE1IF_PERF_EN
  ,
  output logic [15:0] perf_bubble_cnt_out
`endif
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CntW:0] Credits = (CntW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StBoot, StRun, StRedirect} state_e;

  state_e            state_q;
  logic [23:0]       fetch_pc_q, resp_pc_q;
  logic [CntW-1:0]   outst_q, outst_d, discard_q, discard_d, count_q, count_d;
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [23:0]       fifo_pc_q    [FIFO_DEPTH];
  logic [23:0]       fifo_instr_q [FIFO_DEPTH];
  logic [CntW:0]     credit_used;
  logic              accept, resp, keep, load, fifo_empty, pop, bypass, push;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Buffered entries plus in-flight requests never exceed the buffer size.
  assign credit_used = {1'b0, outst_q} + {1'b0, count_q};
  assign imem_req    = (state_q == StRun) && enable_in && !flush_in && (credit_used < Credits);
  assign imem_addr   = imem_req ? fetch_pc_q : 24'h0;
  assign accept      = imem_req && imem_gnt;
  assign resp        = imem_rvalid && (outst_q != '0);
  assign keep        = resp && (discard_q == '0) && !flush_in;
  assign load        = enable_in && !stall_in && !flush_in;
  assign fifo_empty  = (count_q == '0);
  assign pop         = load && !fifo_empty;
  assign bypass      = load && fifo_empty && keep;
  assign push        = keep && !bypass;

  always_comb begin
    outst_d = outst_q;
    if (accept) outst_d = outst_d + CntW'(1);
    if (resp)   outst_d = outst_d - CntW'(1);
    // Everything still in flight after a redirect is stale.
    discard_d = discard_q;
    if (flush_in) discard_d = outst_d;
    else if (resp && (discard_q != '0)) discard_d = discard_q - CntW'(1);
    count_d = count_q;
    if (push) count_d = count_d + CntW'(1);
    if (pop)  count_d = count_d - CntW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StBoot;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      enable_out <= 1'b0;
      pc_out     <= 24'h0;
      instr_out  <= 24'h0;
    end else begin
      outst_q   <= outst_d;
      discard_q <= discard_d;
      unique case (state_q)
        StBoot:            state_q <= StRun;
        StRun, StRedirect: state_q <= (discard_d != '0) ? StRedirect : StRun;
        default:           state_q <= StBoot;
      endcase
      if (flush_in) begin
        fetch_pc_q <= flush_pc_in;
        resp_pc_q  <= flush_pc_in;
        count_q    <= '0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        enable_out <= 1'b0;
        instr_out  <= 24'h0;
      end else begin
        if (accept) fetch_pc_q <= fetch_pc_q + 24'd1;
        if (keep)   resp_pc_q  <= resp_pc_q + 24'd1;
        count_q <= count_d;
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        if (load) begin
          if (!fifo_empty) begin
            enable_out <= 1'b1;
            pc_out     <= fifo_pc_q[rd_ptr_q];
            instr_out  <= fifo_instr_q[rd_ptr_q];
          end else if (keep) begin
            enable_out <= 1'b1;
            pc_out     <= resp_pc_q;
            instr_out  <= imem_rdata;
          end else begin
            enable_out <= 1'b0;
            instr_out  <= 24'h0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

`ifdef STAGE1IF_PERF_EN
  logic bubble;
  assign bubble = load && fifo_empty && !keep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bubble_cnt_out <= 16'h0;
    end else if (bubble && (perf_bubble_cnt_out != 16'hFFFF)) begin
      perf_bubble_cnt_out <= perf_bubble_cnt_out + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stage1if.sv
// Bench for stage1if: directed phases checked against a stream-level model (each consumed
// instruction must be the next pc in program order), plus a second instance reset at FFFFFE.
`timescale 1ns/1ps
module tb_stage1if;
  localparam logic [23:0] XorKey = 24'hA50000;
  localparam int Depth = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable_in, stall_in, flush_in, imem_gnt, imem_rvalid, imem_req, enable_out;
  logic [23:0] flush_pc_in, imem_rdata, imem_addr, pc_out, instr_out;
  logic        rst1, rvalid1, req1, en1;
  logic [23:0] rdata1, addr1, pc1, instr1;
`ifdef STAGE1IF_PERF_EN
  logic [15:0] perf0, perf1;
`endif

  stage1if #(.RESET_PC(24'h000000), .FIFO_DEPTH(Depth)) dut (
    .clk(clk), .rst(rst), .enable_in(enable_in), .stall_in(stall_in), .flush_in(flush_in),
    .flush_pc_in(flush_pc_in), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .enable_out(enable_out), .pc_out(pc_out), .instr_out(instr_out)
`ifdef STAGE1IF_PERF_EN
    , .perf_bubble_cnt_out(perf0)
`endif
  );

  stage1if #(.RESET_PC(24'hFFFFFE), .FIFO_DEPTH(Depth)) dut_wrap (
    .clk(clk), .rst(rst1), .enable_in(1'b1), .stall_in(1'b0), .flush_in(1'b0),
    .flush_pc_in(24'h0), .imem_req(req1), .imem_addr(addr1),
    .imem_gnt(1'b1), .imem_rvalid(rvalid1), .imem_rdata(rdata1),
    .enable_out(en1), .pc_out(pc1), .instr_out(instr1)
`ifdef STAGE1IF_PERF_EN
    , .perf_bubble_cnt_out(perf1)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory: in-order responses, data = addr ^ XorKey, latency in cycles set per phase.
  logic [23:0] mq_addr[$];
  int          mq_due[$];
  int          lat = 1;
  int          cyc = 0;
  logic        gnt_toggle = 1'b0;
  logic        s_req, s_gnt, s_en, s_rv, s1_acc;
  logic [23:0] s_addr, s_pc, s_instr, s1_addr;

  task automatic tick();
    @(negedge clk);
    s_req = imem_req; s_gnt = imem_gnt; s_addr = imem_addr; s_rv = imem_rvalid;
    s_en = enable_out; s_pc = pc_out; s_instr = instr_out;
    s1_acc = req1; s1_addr = addr1;
    @(posedge clk);
    #1;
    cyc++;
    if (s_req && s_gnt) begin
      mq_addr.push_back(s_addr);
      mq_due.push_back(cyc + lat - 1);
    end
    imem_rvalid = 1'b0;
    imem_rdata  = 24'h0;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq_addr[0] ^ XorKey;
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    rvalid1 = s1_acc;
    rdata1  = s1_addr ^ XorKey;
    if (gnt_toggle) imem_gnt = ~imem_gnt;
  endtask

  // Reference model: program-order pc stream, output hold rules, request credits.
  logic [23:0] exp_pc, prev_pc, prev_instr, prev_addr, exp1;
  logic        have_prev, prev_blocked, prev_flush, prev_en, prev_pend, clean;
  int          in_flight, backlog;
  logic [23:0] w_pcs [4];
  int          w_n = 0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_enable_out", 24'(enable_out), 24'h0);
      chk("rst_pc_out", pc_out, 24'h0);
      chk("rst_instr_out", instr_out, 24'h0);
      chk("rst_imem_req", 24'(imem_req), 24'h0);
      chk("rst_imem_addr", imem_addr, 24'h0);
      exp_pc = 24'h0; have_prev = 1'b0; in_flight = 0; backlog = 0; clean = 1'b1;
    end else begin
      if (!enable_out) chk("nop_when_invalid", instr_out, 24'h0);
      if (have_prev && prev_flush) begin
        chk("flush_clears_valid", 24'(enable_out), 24'h0);
        chk("flush_keeps_pc", pc_out, prev_pc);
      end else if (have_prev && prev_blocked) begin
        chk("hold_enable", 24'(enable_out), 24'(prev_en));
        chk("hold_pc", pc_out, prev_pc);
        chk("hold_instr", instr_out, prev_instr);
      end
      if (have_prev && prev_pend && imem_req) chk("addr_stable_ungranted", imem_addr, prev_addr);
      if (enable_out && enable_in && !stall_in && !flush_in) begin
        chk("stream_pc", pc_out, exp_pc);
        chk("stream_instr", instr_out, exp_pc ^ XorKey);
        exp_pc = exp_pc + 24'd1;
        backlog--;
      end
      if (flush_in) begin
        exp_pc = flush_pc_in;
        clean = 1'b0;
      end
      if (imem_rvalid && in_flight > 0) in_flight--;
      if (imem_req && imem_gnt) begin
        in_flight++;
        backlog++;
      end
      chk("credit_in_flight", 24'(in_flight > Depth), 24'h0);
      if (clean) chk("credit_backlog", 24'(backlog > Depth + 1), 24'h0);
      prev_blocked = !enable_in || stall_in;
      prev_flush = flush_in; prev_en = enable_out; prev_pc = pc_out; prev_instr = instr_out;
      prev_pend = imem_req && !imem_gnt; prev_addr = imem_addr; have_prev = 1'b1;
    end
    if (rst1) begin
      exp1 = 24'hFFFFFE;
    end else if (en1) begin
      chk("wrap_stream_pc", pc1, exp1);
      chk("wrap_stream_instr", instr1, exp1 ^ XorKey);
      if (w_n < 4) begin
        w_pcs[w_n] = pc1;
        w_n++;
      end
      exp1 = exp1 + 24'd1;
    end
  end

  logic [23:0] t_req [6], t_addr [6], t_en [6], t_pc [6], t_instr [6], t_rv [6], t_wrap [4];
  logic [23:0] stall_pc;

  initial begin
    rst = 1'b1; rst1 = 1'b1; enable_in = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
    flush_pc_in = 24'h0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 24'h0;
    rvalid1 = 1'b0; rdata1 = 24'h0;
    t_req   = '{24'h0, 24'h1, 24'h1, 24'h1, 24'h1, 24'h1};
    t_addr  = '{24'h0, 24'h0, 24'h1, 24'h2, 24'h3, 24'h4};
    t_rv    = '{24'h0, 24'h0, 24'h1, 24'h1, 24'h1, 24'h1};
    t_en    = '{24'h0, 24'h0, 24'h0, 24'h1, 24'h1, 24'h1};
    t_pc    = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h1, 24'h2};
    t_instr = '{24'h0, 24'h0, 24'h0, 24'hA50000, 24'hA50001, 24'hA50002};
    t_wrap  = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
    repeat (3) tick();
    rst = 1'b0; rst1 = 1'b0;

    // Cycle-exact start-up: BOOT cycle, then addr 0,1,2...; data one cycle after rvalid.
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("startup_req_c%0d", i + 1), 24'(s_req), t_req[i]);
      chk($sformatf("startup_addr_c%0d", i + 1), s_addr, t_addr[i]);
      chk($sformatf("startup_rvalid_c%0d", i + 1), 24'(s_rv), t_rv[i]);
      chk($sformatf("startup_en_c%0d", i + 1), 24'(s_en), t_en[i]);
      chk($sformatf("startup_pc_c%0d", i + 1), s_pc, t_pc[i]);
      chk($sformatf("startup_instr_c%0d", i + 1), s_instr, t_instr[i]);
    end

    // Stall mid-stream for three cycles.
    repeat (3) tick();
    stall_in = 1'b1;
    tick();
    stall_pc = s_pc;
    repeat (2) tick();
    stall_in = 1'b0;
    tick();
    chk("stall_literal_hold", s_pc, stall_pc);
    repeat (8) tick();

    // Redirect with two requests in flight.
    lat = 3;
    for (int k = 0; k < 20 && mq_addr.size() != 2; k++) tick();
    chk("flush_setup_outstanding", 24'(mq_addr.size()), 24'd2);
    flush_in = 1'b1; flush_pc_in = 24'h000100;
    tick();
    flush_in = 1'b0; flush_pc_in = 24'h0;
    tick();
    chk("flush_next_cycle_invalid", 24'(s_en), 24'h0);
    for (int k = 0; k < 30 && !s_en; k++) tick();
    chk("flush_first_valid_seen", 24'(s_en), 24'h1);
    chk("flush_first_pc", s_pc, 24'h000100);
    chk("flush_first_instr", s_instr, 24'hA50100);
    repeat (6) tick();

    // Grant toggling every cycle.
    lat = 1; gnt_toggle = 1'b1;
    repeat (14) tick();
    gnt_toggle = 1'b0; imem_gnt = 1'b1;
    repeat (4) tick();

    // Reset with two requests in flight; their late responses must be ignored.
    lat = 4;
    for (int k = 0; k < 20 && mq_addr.size() != 2; k++) tick();
    chk("reset_setup_outstanding", 24'(mq_addr.size()), 24'd2);
    rst = 1'b1;
    tick();
    chk("reset_en_immediate", 24'(s_en), 24'h0);
    chk("reset_pc_immediate", s_pc, 24'h0);
    chk("reset_instr_immediate", s_instr, 24'h0);
    rst = 1'b0; enable_in = 1'b0;
    for (int k = 0; k < 12 && mq_addr.size() != 0; k++) tick();
    tick();
    chk("reset_late_data_drained", 24'(mq_addr.size()), 24'd0);
    enable_in = 1'b1; lat = 1;
    for (int k = 0; k < 20 && !s_en; k++) tick();
    chk("reset_restart_valid_seen", 24'(s_en), 24'h1);
    chk("reset_restart_pc", s_pc, 24'h000000);
    chk("reset_restart_instr", s_instr, 24'hA50000);
    repeat (6) tick();

    chk("wrap_count", 24'(w_n >= 4), 24'h1);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_pc_%0d", i), w_pcs[i], t_wrap[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
